// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx
//  Description : Memory-mapped 8N1 UART transmitter with a TX FIFO, a
//                programmable bit divisor and a level TX-done interrupt.
//                Decodes a 4 KiB window on a shared device bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        device_ren,
  input  logic        device_wen,
  input  logic [31:0] common_addr,
  input  logic [31:0] common_wdata,
  input  logic [3:0]  common_wstrb,
  output logic [31:0] device_rdata,
  output logic        uart_tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_full_cnt = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic       w_hit;
  logic       w_wr;
  logic       w_rd;
  logic [9:0] w_off;
  logic       w_sel_tx;
  logic       w_sel_stat;
  logic       w_sel_div;
  logic       w_sel_ctrl;

  assign w_hit      = (common_addr[31:12] == BASE_ADDR[31:12]);
  assign w_wr       = device_wen & w_hit;
  assign w_rd       = device_ren & w_hit;
  assign w_off      = common_addr[11:2];
  assign w_sel_tx   = (w_off == 10'd0);
  assign w_sel_stat = (w_off == 10'd1);
  assign w_sel_div  = (w_off == 10'd2);
  assign w_sel_ctrl = (w_off == 10'd3);

  // Byte-lane bits that no register consumes; folded here so they stay tied.
  logic w_unused_bits;
  assign w_unused_bits = &{1'b0, common_addr[1:0], common_wdata[31:16], common_wstrb[3:2]};

  // --------------------------------------------------------------------------
  // Registers and state
  // --------------------------------------------------------------------------
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [15:0]   r_divisor;
  logic          r_irq_en;
  logic          r_irq;

  state_t        r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic [15:0]   r_div_cnt;
  logic [15:0]   r_bit_div;
  logic          r_tx;

  logic          w_full;
  logic          w_empty;
  logic          w_busy;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_clr;
  logic [15:0]   w_div_eff;
  logic          w_bit_end;
  logic [7:0]    w_cnt8;

  assign w_full     = (r_count == c_full_cnt);
  assign w_empty    = (r_count == '0);
  assign w_busy     = (r_state != S_IDLE);
  assign w_push_req = w_wr & w_sel_tx & common_wstrb[0];
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = (r_state == S_IDLE) & ~w_empty;
  assign w_ovf_clr  = w_wr & w_sel_stat & common_wstrb[0] & common_wdata[3];
  assign w_div_eff  = (r_divisor == 16'd0) ? 16'd1 : r_divisor;
  assign w_bit_end  = (r_div_cnt == (r_bit_div - 16'd1));

  // Count field is 8 bits wide; a 256-deep FIFO that is full saturates to FF.
  generate
    if (CW < 9) begin : g_cnt_narrow
      assign w_cnt8 = {{(8-CW){1'b0}}, r_count};
    end else begin : g_cnt_wide
      assign w_cnt8 = r_count[8] ? 8'hFF : r_count[7:0];
    end
  endgenerate

  // FIFO storage: no reset needed, pointers define what is valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= common_wdata[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
      // A push into a full FIFO is lost even when a pop frees a slot this cycle.
      if (w_push_req && w_full) begin
        r_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Software-writable configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divisor <= DIV_RESET;
      r_irq_en  <= 1'b0;
    end else if (w_wr) begin
      if (w_sel_div && common_wstrb[0]) begin
        r_divisor[7:0] <= common_wdata[7:0];
      end
      if (w_sel_div && common_wstrb[1]) begin
        r_divisor[15:8] <= common_wdata[15:8];
      end
      if (w_sel_ctrl && common_wstrb[0]) begin
        r_irq_en <= common_wdata[0];
      end
    end
  end

  // TX framing FSM: start bit, 8 data bits LSB first, stop bit.
  // The bit length is re-latched at every bit boundary so divisor changes
  // made mid-frame only affect the following bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_div_cnt <= 16'd0;
      r_bit_div <= 16'd1;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_div_cnt <= 16'd0;
          r_bit_cnt <= 3'd0;
          if (!w_empty) begin
            r_shift   <= r_mem[r_rd_ptr];
            r_bit_div <= w_div_eff;
            r_tx      <= 1'b0;
            r_state   <= S_START;
          end
        end
        default: begin
          if (w_bit_end) begin
            r_div_cnt <= 16'd0;
            r_bit_div <= w_div_eff;
            case (r_state)
              S_START: begin
                r_tx      <= r_shift[0];
                r_shift   <= {1'b0, r_shift[7:1]};
                r_bit_cnt <= 3'd0;
                r_state   <= S_DATA;
              end
              S_DATA: begin
                if (r_bit_cnt == 3'd7) begin
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
                end else begin
                  r_tx      <= r_shift[0];
                  r_shift   <= {1'b0, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                end
              end
              default: begin
                r_tx    <= 1'b1;
                r_state <= S_IDLE;
              end
            endcase
          end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Registered TX-done interrupt: enabled, nothing queued, line idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en & w_empty & ~w_busy;
    end
  end

  // Combinational read mux; zero whenever the access is not a read hit
  always_comb begin
    device_rdata = 32'h0000_0000;
    if (w_rd) begin
      if (w_sel_stat) begin
        device_rdata = {16'h0000, w_cnt8, 4'h0, r_overflow, w_busy, w_empty, w_full};
      end else if (w_sel_div) begin
        device_rdata = {16'h0000, r_divisor};
      end else if (w_sel_ctrl) begin
        device_rdata = {31'h0, r_irq_en};
      end
    end
  end

  assign uart_tx = r_tx;
  assign irq     = r_irq;

endmodule
`default_nettype wire
